demux_stream_1ton: RTL and testbench

// - Parametrised 1-to-NCH stream demultiplexer with a valid/ready handshake.
//   It routes each input word to the output channel selected by i_sel.
// - Each channel has a one-entry output register, so downstream

---
 rtl/demux_stream_1ton.sv | 75 +++++++
 tb/tb_demux_stream_1ton.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_stream_1ton.sv
// 1-to-NCH valid/ready stream demultiplexer. Each channel has its own one-word output register.
// Words with an out-of-range select are accepted, discarded and counted in a saturating counter.
module demux_stream_1ton #(
   parameter int WIDTH = 8,
   parameter int SNUM  = 1,
   parameter int NCH   = 2,
   parameter int CNTW  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     i_data,
   input  logic [SNUM-1:0]      i_sel,
   input  logic                 i_valid,
   output logic                 i_ready,
   output logic [NCH*WIDTH-1:0] o_data,
   output logic [NCH-1:0]       o_valid,
   input  logic [NCH-1:0]       o_ready,
   output logic [CNTW-1:0]      drop_cnt
);
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ch_state_e;

   ch_state_e                 state_q [NCH];
   ch_state_e                 state_d [NCH];
   logic [NCH-1:0][WIDTH-1:0] data_q, data_d;
   logic [CNTW-1:0]           drop_q, drop_d;
   logic                      sel_ok;
   logic                      acc;
   logic [NCH-1:0]            load;

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      sel_ok  = int'(i_sel) < NCH;
      i_ready = 1'b1;
      o_valid = '0;
      load    = '0;
      for (int c = 0; c < NCH; c++) begin
         if (sel_ok && (i_sel == SNUM'(c)))
            i_ready = (state_q[c] == EMPTY) || o_ready[c];
      end
      acc    = i_valid && i_ready;
      drop_d = drop_q;
      if (acc && !sel_ok && !(&drop_q))
         drop_d = drop_q + CNTW'(1);
      // A load wins over a drain, so a full channel can refill in the cycle it empties.
      for (int c = 0; c < NCH; c++) begin
         load[c]    = acc && sel_ok && (i_sel == SNUM'(c));
         o_valid[c] = (state_q[c] == FULL);
         state_d[c] = state_q[c];
         data_d[c]  = data_q[c];
         if (load[c]) begin
            state_d[c] = FULL;
            data_d[c]  = i_data;
         end else if (o_valid[c] && o_ready[c]) begin
            state_d[c] = EMPTY;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         // NOTE: the data registers are cleared as well, because o_data must read zero after reset.
         for (int c = 0; c < NCH; c++) state_q[c] <= EMPTY;
         data_q <= '0;
         drop_q <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         drop_q  <= drop_d;
      end
   end

   assign o_data   = data_q;
   assign drop_cnt = drop_q;
endmodule

// File: tb/tb_demux_stream_1ton.sv
// Bench for demux_stream_1ton: a 2-channel instance for directed load/stall/reset scenarios,
// and a 3-channel instance for drop saturation and a randomized run against per-channel queues.
module tb_demux_stream_1ton;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Instance A: WIDTH=8, SNUM=1, NCH=2
   logic [7:0]  a_data;
   logic [0:0]  a_sel;
   logic        a_valid, a_ready;
   logic [15:0] a_odata;
   logic [1:0]  a_ovalid, a_oready;
   logic [7:0]  a_drop;

   // Instance B: WIDTH=8, SNUM=2, NCH=3
   logic [7:0]  b_data;
   logic [1:0]  b_sel;
   logic        b_valid, b_ready;
   logic [23:0] b_odata;
   logic [2:0]  b_ovalid, b_oready;
   logic [7:0]  b_drop;

   int passed = 0;
   int total  = 0;

   demux_stream_1ton #(.WIDTH(8), .SNUM(1), .NCH(2), .CNTW(8)) dut_a (
      .clk(clk), .rst(rst), .i_data(a_data), .i_sel(a_sel), .i_valid(a_valid),
      .i_ready(a_ready), .o_data(a_odata), .o_valid(a_ovalid), .o_ready(a_oready),
      .drop_cnt(a_drop)
   );

   demux_stream_1ton #(.WIDTH(8), .SNUM(2), .NCH(3), .CNTW(8)) dut_b (
      .clk(clk), .rst(rst), .i_data(b_data), .i_sel(b_sel), .i_valid(b_valid),
      .i_ready(b_ready), .o_data(b_odata), .o_valid(b_ovalid), .o_ready(b_oready),
      .drop_cnt(b_drop)
   );

   // All tasks start and end 1 time unit after a rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      a_valid = 1'b0; a_data = 8'h00; a_sel = 1'b0; a_oready = 2'b00;
      b_valid = 1'b0; b_data = 8'h00; b_sel = 2'd0; b_oready = 3'b000;
      step();
      step();
      total++; if (a_ovalid !== 2'b00) $display("FAIL reset_a_ovalid got=%b exp=00", a_ovalid); else passed++;
      total++; if (a_odata !== 16'h0) $display("FAIL reset_a_odata got=%h exp=0000", a_odata); else passed++;
      total++; if (a_drop !== 8'h0) $display("FAIL reset_a_drop got=%h exp=00", a_drop); else passed++;
      total++; if (b_ovalid !== 3'b000) $display("FAIL reset_b_ovalid got=%b exp=000", b_ovalid); else passed++;
      total++; if (b_odata !== 24'h0) $display("FAIL reset_b_odata got=%h exp=000000", b_odata); else passed++;
      total++; if (b_drop !== 8'h0) $display("FAIL reset_b_drop got=%h exp=00", b_drop); else passed++;
      for (int s = 0; s < 2; s++) begin
         a_sel = s[0:0];
         #1;
         total++; if (a_ready !== 1'b1) $display("FAIL reset_a_ready sel=%0d got=%b exp=1", s, a_ready); else passed++;
      end
      for (int s = 0; s < 4; s++) begin
         b_sel = s[1:0];
         #1;
         total++; if (b_ready !== 1'b1) $display("FAIL reset_b_ready sel=%0d got=%b exp=1", s, b_ready); else passed++;
      end
      rst = 1'b0;
      a_sel = 1'b0;
      b_sel = 2'd0;
      step();
   endtask

   task automatic test_single_load();
      a_data = 8'hA0; a_sel = 1'b0; a_valid = 1'b1; a_oready = 2'b00;
      step();
      a_valid = 1'b0;
      total++; if (a_ovalid !== 2'b01) $display("FAIL load_ovalid got=%b exp=01", a_ovalid); else passed++;
      total++; if (a_odata[7:0] !== 8'hA0) $display("FAIL load_odata got=%h exp=a0", a_odata[7:0]); else passed++;
      a_sel = 1'b0;
      #1;
      total++; if (a_ready !== 1'b0) $display("FAIL load_ready_sel0 got=%b exp=0", a_ready); else passed++;
      a_sel = 1'b1;
      #1;
      total++; if (a_ready !== 1'b1) $display("FAIL load_ready_sel1 got=%b exp=1", a_ready); else passed++;
      step();
      total++; if (a_ovalid !== 2'b01) $display("FAIL load_hold_ovalid got=%b exp=01", a_ovalid); else passed++;
      total++; if (a_odata[7:0] !== 8'hA0) $display("FAIL load_hold_odata got=%h exp=a0", a_odata[7:0]); else passed++;
   endtask

   task automatic test_back_to_back();
      int b0_seen;
      b0_seen = 0;
      a_data = 8'hB0; a_sel = 1'b1; a_valid = 1'b1; a_oready = 2'b00;
      step();
      a_data = 8'hB1; a_oready = 2'b10;
      #1;
      total++; if (a_ready !== 1'b1) $display("FAIL b2b_ready got=%b exp=1", a_ready); else passed++;
      if (a_ovalid[1] && a_oready[1] && a_odata[15:8] == 8'hB0) b0_seen++;
      step();
      a_valid = 1'b0;
      if (a_ovalid[1] && a_oready[1] && a_odata[15:8] == 8'hB0) b0_seen++;
      a_oready = 2'b00;
      total++; if (a_ovalid !== 2'b11) $display("FAIL b2b_ovalid got=%b exp=11", a_ovalid); else passed++;
      total++; if (a_odata[15:8] !== 8'hB1) $display("FAIL b2b_odata_ch1 got=%h exp=b1", a_odata[15:8]); else passed++;
      total++; if (a_odata[7:0] !== 8'hA0) $display("FAIL b2b_odata_ch0 got=%h exp=a0", a_odata[7:0]); else passed++;
      total++; if (b0_seen !== 1) $display("FAIL b2b_b0_consumed got=%0d exp=1", b0_seen); else passed++;
   endtask

   task automatic test_mid_reset();
      total++; if (a_ovalid !== 2'b11) $display("FAIL mrst_pre_ovalid got=%b exp=11", a_ovalid); else passed++;
      rst = 1'b1; a_valid = 1'b1; a_sel = 1'b0; a_data = 8'h55; a_oready = 2'b00;
      step();
      rst = 1'b0; a_valid = 1'b0;
      total++; if (a_ovalid !== 2'b00) $display("FAIL mrst_ovalid got=%b exp=00", a_ovalid); else passed++;
      total++; if (a_odata !== 16'h0) $display("FAIL mrst_odata got=%h exp=0000", a_odata); else passed++;
      a_oready = 2'b11;
      for (int n = 0; n < 3; n++) begin
         step();
         total++; if (a_ovalid !== 2'b00) $display("FAIL mrst_stale_ovalid cyc=%0d got=%b exp=00", n, a_ovalid); else passed++;
      end
      a_oready = 2'b00;
   endtask

   task automatic test_drop();
      b_oready = 3'b000; b_sel = 2'd3; b_data = 8'h77; b_valid = 1'b1;
      #1;
      total++; if (b_ready !== 1'b1) $display("FAIL drop_ready got=%b exp=1", b_ready); else passed++;
      step();
      total++; if (b_ovalid !== 3'b000) $display("FAIL drop_ovalid got=%b exp=000", b_ovalid); else passed++;
      total++; if (b_drop !== 8'd1) $display("FAIL drop_cnt1 got=%0d exp=1", b_drop); else passed++;
      for (int n = 0; n < 253; n++) step();
      total++; if (b_drop !== 8'hFE) $display("FAIL drop_cnt254 got=%h exp=fe", b_drop); else passed++;
      step();
      total++; if (b_drop !== 8'hFF) $display("FAIL drop_cnt255 got=%h exp=ff", b_drop); else passed++;
      for (int n = 0; n < 45; n++) step();
      b_valid = 1'b0;
      total++; if (b_drop !== 8'hFF) $display("FAIL drop_cnt300 got=%h exp=ff", b_drop); else passed++;
      total++; if (b_ovalid !== 3'b000) $display("FAIL drop_ovalid300 got=%b exp=000", b_ovalid); else passed++;
   endtask

   task automatic test_random_stress();
      logic [7:0] sb [3][$];
      int drops;
      int s;
      bit exp_ready;
      bit exp_v;
      int exp_drop;
      rst = 1'b1; b_valid = 1'b0;
      step();
      step();
      rst = 1'b0;
      drops = 0;
      for (int n = 0; n < 10000; n++) begin
         b_valid  = 1'($urandom_range(0, 1));
         b_sel    = 2'($urandom_range(0, 3));
         b_data   = 8'($urandom);
         b_oready = 3'($urandom);
         #1;
         s = int'(b_sel);
         exp_ready = (s >= 3) || (sb[s].size() == 0) || b_oready[s];
         if (b_ready !== exp_ready) begin
            total++;
            $display("FAIL rand_ready cyc=%0d sel=%0d got=%b exp=%b", n, s, b_ready, exp_ready);
         end else begin
            total++; passed++;
         end
         for (int c = 0; c < 3; c++) begin
            exp_v = sb[c].size() != 0;
            total++; if (b_ovalid[c] !== exp_v) $display("FAIL rand_ovalid cyc=%0d ch=%0d got=%b exp=%b", n, c, b_ovalid[c], exp_v); else passed++;
            if (exp_v) begin
               total++; if (b_odata[c*8 +: 8] !== sb[c][0]) $display("FAIL rand_odata cyc=%0d ch=%0d got=%h exp=%h", n, c, b_odata[c*8 +: 8], sb[c][0]); else passed++;
               if (b_oready[c]) void'(sb[c].pop_front());
            end
         end
         if (b_valid && exp_ready) begin
            if (s >= 3) drops++;
            else sb[s].push_back(b_data);
         end
         step();
         exp_drop = (drops > 255) ? 255 : drops;
         total++; if (int'(b_drop) !== exp_drop) $display("FAIL rand_drop cyc=%0d got=%0d exp=%0d", n, b_drop, exp_drop); else passed++;
      end
      b_valid = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_load();
      test_back_to_back();
      test_mid_reset();
      test_drop();
      test_random_stress();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
